// File: rtl/exe_alu_stage_if.sv
// EX-stage bundle: operands and controls into the ALU stage, registered EX/MEM fields out.
// The upstream pipeline and hazard logic use the master side; the stage itself uses the slave side.
interface exe_alu_stage_if;

   // Hazard / branch controls
   logic        freeze;
   logic        flush;

   // Instruction arriving from the operand generator
   logic        valid_in;
   logic [3:0]  exe_cmd;
   logic        s_bit;
   logic [31:0] val1;
   logic [31:0] val2;
   logic [31:0] st_val_in;
   logic [3:0]  dest_in;
   logic        wb_en_in;
   logic        mem_r_en_in;
   logic        mem_w_en_in;

   // EX/MEM register contents
   logic [31:0] alu_res;
   logic [31:0] st_val;
   logic [3:0]  dest;
   logic        wb_en;
   logic        mem_r_en;
   logic        mem_w_en;
   logic        valid_out;

   // Architectural NZCV flags
   logic [3:0]  status;

   modport master (
      output freeze, flush, valid_in, exe_cmd, s_bit, val1, val2, st_val_in, dest_in,
             wb_en_in, mem_r_en_in, mem_w_en_in,
      input  alu_res, st_val, dest, wb_en, mem_r_en, mem_w_en, valid_out, status
   );

   modport slave (
      input  freeze, flush, valid_in, exe_cmd, s_bit, val1, val2, st_val_in, dest_in,
             wb_en_in, mem_r_en_in, mem_w_en_in,
      output alu_res, st_val, dest, wb_en, mem_r_en, mem_w_en, valid_out, status
   );

endinterface

// File: rtl/exe_alu_stage.sv
// Execute-stage ALU with NZCV status register and EX/MEM boundary register.
// One-cycle latency; synchronous reset, flush clears the boundary register, freeze holds it.
module exe_alu_stage (
   input  logic            clk,
   input  logic            rst,
   exe_alu_stage_if.slave  bus
);

   // Operation codes
   localparam logic [3:0] CmdMov = 4'b0001;
   localparam logic [3:0] CmdMvn = 4'b1001;
   localparam logic [3:0] CmdAdd = 4'b0010;
   localparam logic [3:0] CmdAdc = 4'b0011;
   localparam logic [3:0] CmdSub = 4'b0100;
   localparam logic [3:0] CmdSbc = 4'b0101;
   localparam logic [3:0] CmdAnd = 4'b0110;
   localparam logic [3:0] CmdOrr = 4'b0111;
   localparam logic [3:0] CmdEor = 4'b1000;

   // Flag bit positions inside status
   localparam int unsigned FlagN = 3;
   localparam int unsigned FlagZ = 2;
   localparam int unsigned FlagC = 1;
   localparam int unsigned FlagV = 0;

   // Registered state
   logic [31:0] alu_res_q,   alu_res_d;
   logic [31:0] st_val_q,    st_val_d;
   logic [3:0]  dest_q,      dest_d;
   logic        wb_en_q,     wb_en_d;
   logic        mem_r_en_q,  mem_r_en_d;
   logic        mem_w_en_q,  mem_w_en_d;
   logic        valid_q,     valid_d;
   logic [3:0]  status_q,    status_d;

   // ALU internals
   logic        is_add;
   logic        is_sub;
   logic        is_arith;
   logic        is_legal;
   logic        carry_in;
   logic [31:0] adder_b;
   logic [32:0] sum;
   logic [31:0] result;
   logic        flag_n;
   logic        flag_z;
   logic        flag_c;
   logic        flag_v;
   logic        status_we;

   // Decode the operation class and the adder's carry-in
   always_comb begin
      is_add   = 1'b0;
      is_sub   = 1'b0;
      carry_in = 1'b0;
      unique case (bus.exe_cmd)
         CmdAdd:  is_add = 1'b1;
         CmdAdc:  begin
            is_add   = 1'b1;
            carry_in = status_q[FlagC];
         end
         CmdSub:  begin
            is_sub   = 1'b1;
            carry_in = 1'b1;
         end
         // SBC subtracts !C, which in the val1 + ~val2 + cin form means cin = C
         CmdSbc:  begin
            is_sub   = 1'b1;
            carry_in = status_q[FlagC];
         end
         default: ;
      endcase
   end

   assign is_arith = is_add | is_sub;

   // Shared 33-bit adder; subtraction is val1 + ~val2 + cin so bit 32 is NOT borrow
   always_comb begin
      adder_b = is_sub ? ~bus.val2 : bus.val2;
      sum     = {1'b0, bus.val1} + {1'b0, adder_b} + {32'd0, carry_in};
   end

   // Select the result; illegal codes produce zero and never touch the flags
   always_comb begin
      result   = 32'd0;
      is_legal = 1'b1;
      case (bus.exe_cmd)
         CmdMov:                         result = bus.val2;
         CmdMvn:                         result = ~bus.val2;
         CmdAdd, CmdAdc, CmdSub, CmdSbc: result = sum[31:0];
         CmdAnd:                         result = bus.val1 & bus.val2;
         CmdOrr:                         result = bus.val1 | bus.val2;
         CmdEor:                         result = bus.val1 ^ bus.val2;
         default:                        is_legal = 1'b0;
      endcase
   end

   // Compute candidate flags; C and V only change for arithmetic operations
   always_comb begin
      flag_n = result[31];
      flag_z = (result == 32'd0);
      flag_c = status_q[FlagC];
      flag_v = status_q[FlagV];
      if (is_add) begin
         flag_c = sum[32];
         flag_v = (bus.val1[31] == bus.val2[31]) && (result[31] != bus.val1[31]);
      end else if (is_sub) begin
         flag_c = sum[32];
         flag_v = (bus.val1[31] != bus.val2[31]) && (result[31] != bus.val1[31]);
      end
      status_we = bus.valid_in & bus.s_bit & is_legal;
      status_d  = status_q;
      if (status_we) begin
         status_d[FlagN] = flag_n;
         status_d[FlagZ] = flag_z;
         if (is_arith) begin
            status_d[FlagC] = flag_c;
            status_d[FlagV] = flag_v;
         end
      end
   end

   // Next-state of the boundary register for a normal (unfrozen, unflushed) edge
   always_comb begin
      alu_res_d  = result;
      st_val_d   = bus.st_val_in;
      dest_d     = bus.dest_in;
      wb_en_d    = bus.wb_en_in    & bus.valid_in;
      mem_r_en_d = bus.mem_r_en_in & bus.valid_in;
      mem_w_en_d = bus.mem_w_en_in & bus.valid_in;
      valid_d    = bus.valid_in;
   end

   // EX/MEM register: reset > flush (clear) > freeze (hold) > load
   always_ff @(posedge clk) begin
      if (rst || bus.flush) begin
         alu_res_q  <= 32'd0;
         st_val_q   <= 32'd0;
         dest_q     <= 4'd0;
         wb_en_q    <= 1'b0;
         mem_r_en_q <= 1'b0;
         mem_w_en_q <= 1'b0;
         valid_q    <= 1'b0;
      end else if (!bus.freeze) begin
         alu_res_q  <= alu_res_d;
         st_val_q   <= st_val_d;
         dest_q     <= dest_d;
         wb_en_q    <= wb_en_d;
         mem_r_en_q <= mem_r_en_d;
         mem_w_en_q <= mem_w_en_d;
         valid_q    <= valid_d;
      end
   end

   // Status register: cleared by reset, held by both flush and freeze
   always_ff @(posedge clk) begin
      if (rst) begin
         status_q <= 4'd0;
      end else if (!bus.flush && !bus.freeze) begin
         status_q <= status_d;
      end
   end

   assign bus.alu_res   = alu_res_q;
   assign bus.st_val    = st_val_q;
   assign bus.dest      = dest_q;
   assign bus.wb_en     = wb_en_q;
   assign bus.mem_r_en  = mem_r_en_q;
   assign bus.mem_w_en  = mem_w_en_q;
   assign bus.valid_out = valid_q;
   assign bus.status    = status_q;

endmodule

// File: tb/tb_exe_alu_stage.sv
// Bench for exe_alu_stage: directed scenarios followed by random traffic, checked by a
// scoreboard queue filled by the stimulus and drained by an independent monitor.
module tb_exe_alu_stage;

   typedef struct packed {
      logic [31:0] res;
      logic [31:0] stv;
      logic [3:0]  dst;
      logic        wb;
      logic        mr;
      logic        mw;
      logic        vo;
      logic [3:0]  nzcv;
   } out_t;

   logic clk = 1'b0;
   logic rst;
   int   n_tests = 0;
   int   n_fail  = 0;
   int   cyc     = 0;

   out_t exp_q[$];
   out_t m_out;
   out_t e_mon;
   out_t a_mon;

   exe_alu_stage_if bus ();

   exe_alu_stage dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Reference ALU from plain integer arithmetic: unsigned range gives C, signed range gives V
   function automatic void model_alu(input logic [3:0] cmd, input logic [31:0] a,
                                     input logic [31:0] b, input logic c_cur,
                                     output logic [31:0] r, output logic legal,
                                     output logic arith, output logic c, output logic v);
      longint ua, ub, sa, sb, u, s, k;
      ua = longint'(a);
      ub = longint'(b);
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      legal = 1'b1;
      arith = 1'b0;
      c = 1'b0;
      v = 1'b0;
      r = 32'd0;
      case (cmd)
         4'd1: r = b;
         4'd9: r = ~b;
         4'd6: r = a & b;
         4'd7: r = a | b;
         4'd8: r = a ^ b;
         4'd2, 4'd3: begin
            k = (cmd == 4'd3) ? longint'(c_cur) : 64'sd0;
            u = ua + ub + k;
            s = sa + sb + k;
            r = u[31:0];
            c = (u >= 64'sd4294967296);
            v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            arith = 1'b1;
         end
         4'd4, 4'd5: begin
            k = (cmd == 4'd5) ? longint'(!c_cur) : 64'sd0;
            u = ua - ub - k;
            s = sa - sb - k;
            r = u[31:0];
            c = (u >= 64'sd0);
            v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            arith = 1'b1;
         end
         default: legal = 1'b0;
      endcase
   endfunction

   // Drive one cycle of inputs, predict the state after the next edge, then advance
   task automatic step(input logic r, input logic fz, input logic fl, input logic vi,
                       input logic [3:0] cmd, input logic s, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] sv, input logic [3:0] d,
                       input logic w, input logic mr, input logic mw);
      logic [31:0] res;
      logic        legal, arith, c, v;
      rst             = r;
      bus.freeze      = fz;
      bus.flush       = fl;
      bus.valid_in    = vi;
      bus.exe_cmd     = cmd;
      bus.s_bit       = s;
      bus.val1        = a;
      bus.val2        = b;
      bus.st_val_in   = sv;
      bus.dest_in     = d;
      bus.wb_en_in    = w;
      bus.mem_r_en_in = mr;
      bus.mem_w_en_in = mw;
      if (r) begin
         m_out = '0;
      end else if (fl) begin
         m_out = '{res: 32'd0, stv: 32'd0, dst: 4'd0, wb: 1'b0, mr: 1'b0, mw: 1'b0,
                   vo: 1'b0, nzcv: m_out.nzcv};
      end else if (!fz) begin
         model_alu(cmd, a, b, m_out.nzcv[1], res, legal, arith, c, v);
         if (vi && s && legal) begin
            m_out.nzcv[3] = res[31];
            m_out.nzcv[2] = (res == 32'd0);
            if (arith) m_out.nzcv[1:0] = {c, v};
         end
         m_out.res = res;
         m_out.stv = sv;
         m_out.dst = d;
         m_out.wb  = w & vi;
         m_out.mr  = mr & vi;
         m_out.mw  = mw & vi;
         m_out.vo  = vi;
      end
      exp_q.push_back(m_out);
      @(posedge clk);
      #1;
   endtask

   // Plain valid instruction with no hazard controls and fixed pass-through fields
   task automatic op(input logic [3:0] cmd, input logic s, input logic [31:0] a,
                     input logic [31:0] b);
      step(1'b0, 1'b0, 1'b0, 1'b1, cmd, s, a, b, 32'hA5A5_0000 ^ a, 4'd7, 1'b1, 1'b0, 1'b0);
   endtask

   function automatic logic [31:0] pick32();
      case ($urandom_range(0, 7))
         0:       return 32'h0000_0000;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h7FFF_FFFF;
         3:       return 32'h8000_0000;
         4:       return 32'h0000_0001;
         default: return $urandom;
      endcase
   endfunction

   task automatic rand_step(input logic r);
      step(r, ($urandom_range(0, 7) == 0), ($urandom_range(0, 9) == 0),
           ($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)), 1'($urandom),
           pick32(), pick32(), $urandom, 4'($urandom), 1'($urandom), 1'($urandom),
           1'($urandom));
   endtask

   // Monitor: every edge that had stimulus yields one expected record to compare
   initial begin
      forever begin
         @(negedge clk);
         cyc++;
         if (exp_q.size() != 0) begin
            e_mon = exp_q.pop_front();
            a_mon = '{res: bus.alu_res, stv: bus.st_val, dst: bus.dest, wb: bus.wb_en,
                      mr: bus.mem_r_en, mw: bus.mem_w_en, vo: bus.valid_out,
                      nzcv: bus.status};
            n_tests++;
            if (a_mon !== e_mon) begin
               n_fail++;
               $display("FAIL cycle%0d: got res=%h st=%h dest=%h wb/mr/mw/vo=%b%b%b%b nzcv=%b, expected res=%h st=%h dest=%h wb/mr/mw/vo=%b%b%b%b nzcv=%b",
                        cyc, a_mon.res, a_mon.stv, a_mon.dst, a_mon.wb, a_mon.mr, a_mon.mw,
                        a_mon.vo, a_mon.nzcv, e_mon.res, e_mon.stv, e_mon.dst, e_mon.wb,
                        e_mon.mr, e_mon.mw, e_mon.vo, e_mon.nzcv);
            end
         end
      end
   end

   initial begin
      m_out = '0;
      // Reset for two cycles with random inputs
      rand_step(1'b1);
      rand_step(1'b1);

      // Carry / zero, then ADC consuming that carry
      op(4'b0010, 1'b1, 32'hFFFF_FFFF, 32'h0000_0001);
      op(4'b0011, 1'b0, 32'h0, 32'h0);

      // Signed overflow on add then on subtract (leaves status 0011)
      op(4'b0010, 1'b1, 32'h7FFF_FFFF, 32'h0000_0001);
      op(4'b0100, 1'b1, 32'h8000_0000, 32'h0000_0001);

      // Logical ops keep C and V; MVN without S leaves flags alone
      op(4'b0110, 1'b1, 32'hF0F0_F0F0, 32'h0F0F_0F0F);
      op(4'b1001, 1'b0, 32'h0, 32'h0);

      // Borrow handling
      op(4'b0100, 1'b1, 32'd5, 32'd5);
      op(4'b0101, 1'b0, 32'd5, 32'd3);
      op(4'b0100, 1'b1, 32'd3, 32'd5);
      op(4'b0101, 1'b0, 32'd5, 32'd3);

      // Freeze for three cycles with an ADDS waiting, then release it
      repeat (3) step(1'b0, 1'b1, 1'b0, 1'b1, 4'b0010, 1'b1, 32'h8000_0000, 32'h8000_0000,
                      32'h1234_5678, 4'd3, 1'b1, 1'b1, 1'b1);
      step(1'b0, 1'b0, 1'b0, 1'b1, 4'b0010, 1'b1, 32'h8000_0000, 32'h8000_0000,
           32'h1234_5678, 4'd3, 1'b1, 1'b1, 1'b1);

      // Flush with an ADDS, and flush together with freeze
      step(1'b0, 1'b0, 1'b1, 1'b1, 4'b0010, 1'b1, 32'hFFFF_FFFF, 32'h1, 32'h55, 4'd9,
           1'b1, 1'b1, 1'b1);
      op(4'b0001, 1'b0, 32'h0, 32'hDEAD_BEEF);
      step(1'b0, 1'b1, 1'b1, 1'b1, 4'b0100, 1'b1, 32'h1, 32'h2, 32'h66, 4'd2,
           1'b1, 1'b0, 1'b1);

      // Illegal code with S set
      op(4'b1111, 1'b1, 32'h1234, 32'h5678);

      // Invalid slot loads data but drops controls
      step(1'b0, 1'b0, 1'b0, 1'b0, 4'b0111, 1'b1, 32'h0F, 32'hF0, 32'h77, 4'd4,
           1'b1, 1'b1, 1'b1);

      // Reset mid-stream while frozen and flushed
      step(1'b1, 1'b1, 1'b1, 1'b1, 4'b0010, 1'b1, 32'h1, 32'h1, 32'h1, 4'd1,
           1'b1, 1'b1, 1'b1);

      repeat (400) rand_step($urandom_range(0, 49) == 0);

      @(negedge clk);
      #1;
      n_tests++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: %0d records left, expected 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
